// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: ARM condition codes
// and bit positions inside the NZCV flags register.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: decides whether an instruction with
// the given condition field executes under the supplied NZCV flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-to-memory conditional-execution stage: gates control intents by the
// ARM condition, owns the NZCV register and a one-entry output register.
// Optional COND_STATS_EN adds executed/squashed instruction counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   cond,
  input  logic [1:0]   flag_write,
  input  logic         reg_write_in,
  input  logic         mem_write_in,
  input  logic         pc_src_in,
  input  logic [M-1:0] alu_result,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_result,
  output logic         reg_write,
  output logic         mem_write,
  output logic         pc_src,
  output logic         cond_ex,
  output logic [3:0]   flags
`ifdef COND_STATS_EN
  ,
  output logic [31:0]  exec_count,
  output logic [31:0]  squash_count
`endif
);

  logic       accept;
  logic       pass;
  logic [3:0] flags_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Evaluated against the current register, so an instruction never sees its own flag update.
  cond_check u_cond_check (
    .cond (cond),
    .nzcv (flags),
    .pass (pass)
  );

  always_comb begin
    flags_next = flags;
    if (flag_write[1]) begin
      flags_next[FLAG_N] = alu_n;
      flags_next[FLAG_Z] = alu_z;
    end
    if (flag_write[0]) begin
      flags_next[FLAG_C] = alu_c;
      flags_next[FLAG_V] = alu_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      reg_write  <= 1'b0;
      mem_write  <= 1'b0;
      pc_src     <= 1'b0;
      cond_ex    <= 1'b0;
      flags      <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      reg_write  <= reg_write_in && pass;
      mem_write  <= mem_write_in && pass;
      pc_src     <= pc_src_in && pass;
      cond_ex    <= pass;
      if (pass) begin
        flags <= flags_next;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef COND_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_count   <= '0;
      squash_count <= '0;
    end else if (accept) begin
      if (pass) begin
        exec_count <= exec_count + 32'd1;
      end else begin
        squash_count <= squash_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit; covers condition gating, flag
// updates, stalls and reset. Counter checks are active under COND_STATS_EN.
module tb_cond_unit;

  localparam int unsigned M = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   cond;
  logic [1:0]   flag_write;
  logic         reg_write_in, mem_write_in, pc_src_in;
  logic [M-1:0] alu_result;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_result;
  logic         reg_write, mem_write, pc_src, cond_ex;
  logic [3:0]   flags;
`ifdef COND_STATS_EN
  logic [31:0]  exec_count, squash_count;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  cond_unit #(.M(M)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cond         (cond),
    .flag_write   (flag_write),
    .reg_write_in (reg_write_in),
    .mem_write_in (mem_write_in),
    .pc_src_in    (pc_src_in),
    .alu_result   (alu_result),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .pc_src       (pc_src),
    .cond_ex      (cond_ex),
    .flags        (flags)
`ifdef COND_STATS_EN
    ,
    .exec_count   (exec_count),
    .squash_count (squash_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] nzcv,
                       input logic rwi, input logic mwi, input logic psi,
                       input logic [M-1:0] res);
    in_valid     = 1'b1;
    cond         = c;
    flag_write   = fw;
    alu_n        = nzcv[3];
    alu_z        = nzcv[2];
    alu_c        = nzcv[1];
    alu_v        = nzcv[0];
    reg_write_in = rwi;
    mem_write_in = mwi;
    pc_src_in    = psi;
    alu_result   = res;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cond = 4'hE;
    flag_write = 2'b00;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
    {reg_write_in, mem_write_in, pc_src_in} = 3'b000;
    alu_result = '0;
    step;
    step;
    rst = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_flags", flags, 0);
    check("rst_out_result", out_result, 0);
    check("rst_cond_ex", cond_ex, 0);
    check("rst_controls", {reg_write, mem_write, pc_src}, 0);
    check("rst_in_ready", in_ready, 1);

    // Always-execute instruction writing all four flags
    drive(4'hE, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 32'h1234);
    step;
    check("al_out_valid", out_valid, 1);
    check("al_cond_ex", cond_ex, 1);
    check("al_flags", flags, 4'b1010);
    check("al_result", out_result, 32'h1234);

    // flags=0100 then EQ passes, NE squashes without touching flags
    drive(4'hE, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 32'h0);
    step;
    check("set_z_flags", flags, 4'b0100);
    drive(4'h0, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h11);
    step;
    check("eq_reg_write", reg_write, 1);
    check("eq_cond_ex", cond_ex, 1);
    drive(4'h1, 2'b11, 4'b1011, 1'b1, 1'b1, 1'b1, 32'h22);
    step;
    check("ne_reg_write", reg_write, 0);
    check("ne_controls", {mem_write, pc_src}, 0);
    check("ne_cond_ex", cond_ex, 0);
    check("ne_flags_hold", flags, 4'b0100);
    check("ne_out_valid", out_valid, 1);
    check("ne_result_loaded", out_result, 32'h22);

    // Back-to-back: CMP-like flag write consumed by the next instruction
    drive(4'hE, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    step;
    check("clear_flags", flags, 0);
    drive(4'hE, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0, 32'h0);
    step;
    check("cmp_flags", flags, 4'b0110);
    drive(4'h0, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h33);
    step;
    check("b2b_eq_cond_ex", cond_ex, 1);
    check("b2b_eq_mem_write", mem_write, 1);
    drive(4'hF, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 32'h5555);
    step;
    check("nv_cond_ex", cond_ex, 0);
    check("nv_controls", {reg_write, mem_write, pc_src}, 0);
    check("nv_flags_hold", flags, 4'b0110);

    // Stall: downstream not ready for three cycles
    out_ready = 1'b0;
    drive(4'hE, 2'b11, 4'b1111, 1'b1, 1'b0, 1'b0, 32'hBEEF);
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      check("stall_out_valid", out_valid, 1);
      check("stall_result", out_result, 32'h5555);
      check("stall_flags", flags, 4'b0110);
      check("stall_in_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    step;
    check("release_result", out_result, 32'hBEEF);
    check("release_flags", flags, 4'b1111);
    check("release_reg_write", reg_write, 1);

    // GT under N!=V fails, under N==V with Z=0 passes
    in_valid = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("rst2_flags", flags, 0);
    drive(4'hE, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0, 32'h0);
    step;
    check("gt_setup1_flags", flags, 4'b1000);
    drive(4'hC, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0);
    step;
    check("gt_fail_cond_ex", cond_ex, 0);
    drive(4'hE, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0, 32'h0);
    step;
    check("gt_setup2_flags", flags, 4'b1001);
    drive(4'hC, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0);
    step;
    check("gt_pass_cond_ex", cond_ex, 1);
`ifdef COND_STATS_EN
    check("exec_count", exec_count, 3);
    check("squash_count", squash_count, 1);
`endif

    // Partial flag writes: C,V only then N,Z only
    drive(4'hE, 2'b01, 4'b0110, 1'b0, 1'b0, 1'b0, 32'h0);
    step;
    check("fw01_flags", flags, 4'b1010);
    drive(4'hE, 2'b10, 4'b0101, 1'b0, 1'b0, 1'b0, 32'h0);
    step;
    check("fw10_flags", flags, 4'b0110);

    // Drain with no new input
    in_valid = 1'b0;
    step;
    check("drain_out_valid", out_valid, 0);

    // Reset wins over a simultaneous accept
    drive(4'hE, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 32'hCAFE);
    step;
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst3_out_valid", out_valid, 0);
    check("rst3_flags", flags, 0);
    check("rst3_result", out_result, 0);
    check("rst3_controls", {cond_ex, reg_write, mem_write, pc_src}, 0);
`ifdef COND_STATS_EN
    check("rst3_counters", exec_count | squash_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
